// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// In-order {PC, instruction} FIFO between the fetch path and the Tomasulo
// issue stage. Presents the oldest entry first-word-fall-through, pre-classifies
// it as load/store or branch, and back-pressures fetch when full.

module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    input  logic [31:0]      fetch_instr,
    output logic             fetch_ready,
    output logic             issue_valid,
    output logic [31:0]      issue_pc,
    output logic [31:0]      issue_instr,
    output logic             issue_is_ls,
    output logic             issue_is_br,
    input  logic             issue_ready,
    input  logic             flush,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [31:0]      pcMem_q    [DEPTH];
    logic [31:0]      instrMem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push;
    logic             pop;
    logic [31:0]      headPc;
    logic [31:0]      headInstr;

    // Full/empty come only from the occupancy count; ready never looks at issue_ready
    assign fetch_ready = (count_q != CNT_FULL);
    assign issue_valid = (count_q != '0);
    assign count       = count_q;

    assign push = fetch_valid & fetch_ready;
    assign pop  = issue_valid & issue_ready;

    // Stale array contents stay hidden behind the empty gate
    assign headPc      = pcMem_q[rdPtr_q];
    assign headInstr   = instrMem_q[rdPtr_q];
    assign issue_pc    = issue_valid ? headPc    : '0;
    assign issue_instr = issue_valid ? headInstr : '0;

    // Next-state for pointers and occupancy; flush drops any same-cycle push/pop
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers; reset outranks flush and empties the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage write; the array itself is never cleared
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            pcMem_q[wrPtr_q]    <= fetch_pc;
            instrMem_q[wrPtr_q] <= fetch_instr;
        end
    end

    // Head classification so stall selection upstream needs no extra decode
    always_comb begin
        issue_is_ls = 1'b0;
        issue_is_br = 1'b0;
        if (issue_valid) begin
            case (headInstr[6:0])
                OP_LOAD, OP_STORE:         issue_is_ls = 1'b1;
                OP_BRANCH, OP_JAL, OP_JALR: issue_is_br = 1'b1;
                default: begin
                    issue_is_ls = 1'b0;
                    issue_is_br = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- In-order instruction FIFO between the instruction-memory fetch path and the Tomasulo issue stage.
- Each cycle it captures one fetched {PC, instruction} pair and presents the oldest pair to issue.
- Absorbs reservation-station stalls without losing fetched words and back-pressures PC_logic when full.
- Pre-classifies the head instruction so that upstream stall selection (A_stall vs LS_stall) needs no extra decode.

Parameters:
- DEPTH, 4: number of queue entries. Must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH): read/write pointer width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- fetch_valid  input  1  fetch_pc/fetch_instr are valid this cycle
- fetch_pc  input  32  PC of the fetched word
- fetch_instr  input  32  fetched instruction word
- fetch_ready  output  1  queue can accept a push this cycle
- issue_valid  output  1  head entry present
- issue_pc  output  32  PC of head entry
- issue_instr  output  32  instruction of head entry
- issue_is_ls  output  1  head opcode is 7'b0000011 (load) or 7'b0100011 (store)
- issue_is_br  output  1  head opcode is 7'b1100011, 7'b1101111 or 7'b1100111
- issue_ready  input  1  issue stage consumes the head this cycle
- flush  input  1  discard all entries (branch redirect)
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (synchronous, highest priority):
  - wr_ptr, rd_ptr and count go to 0.
  - Next cycle: issue_valid=0, fetch_ready=1; issue_pc, issue_instr, issue_is_ls and issue_is_br are all 0.
- Push: occurs when fetch_valid & fetch_ready. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: occurs when issue_valid & issue_ready. rd_ptr increments modulo DEPTH.
- Pointer wrap: natural wrap at DEPTH. Full/empty are determined solely by count, not by pointer comparison.
- fetch_ready = (count != DEPTH).
  - It has no combinational dependence on issue_ready.
  - Consequence: when the queue is full, no push is accepted even if a pop occurs in the same cycle.
- issue_valid = (count != 0).
- Head outputs:
  - issue_pc, issue_instr and the class flags are read combinationally from the entry at rd_ptr (first-word-fall-through).
  - All head outputs are forced to 0 when count==0.
- Latency: an instruction pushed at edge N is visible on issue_* after edge N (one cycle). There is no empty-queue bypass.
- Simultaneous push and pop (count strictly between 0 and DEPTH): both pointers advance and count is unchanged.
- Push into an empty queue while issue_ready=1: no pop occurs that cycle because issue_valid=0. count becomes 1.
- Pop with issue_ready high while empty: ignored; no pointer movement.
- Flush:
  - The next edge sets count, wr_ptr and rd_ptr to 0.
  - A push or pop requested in the same cycle is dropped.
  - reset has priority over flush.
- Reset asserted mid-operation: all contents are discarded, identical to the power-on state. No partial entry survives.
- Classification:
  - Purely combinational, from issue_instr[6:0].
  - Unknown opcodes give is_ls=0 and is_br=0.
  - The flags are mutually exclusive.
- count is updated on every edge as count + push - pop. It never exceeds DEPTH and never underflows.
- Storage array contents are not reset; the head output gating ensures stale data is never visible.

Test Plan:
- Reset, then idle → issue_valid=0, fetch_ready=1, count=0, issue_pc=0, issue_instr=0.
- Push PC=0x0 instr=0x00500093, issue_ready=0 → next cycle: issue_valid=1, issue_pc=0x0, issue_instr=0x00500093, is_ls=0, is_br=0, count=1.
- DEPTH=4, push PC 0x0/0x4/0x8/0xC with issue_ready=0 → count=4, fetch_ready=0.
  - A fifth push of PC 0x10 is held off.
  - Then pulse issue_ready for 1 cycle → head becomes 0x4, count=3, fetch_ready=1.
- Continuous push and pop for 10 cycles, PCs 0x0..0x24, starting with count=2 → count stays 2, pops emerge in strict PC order, and pointers wrap past entry 3 cleanly.
- Head instr 0x0002A303 (lw) → is_ls=1, is_br=0. Head instr 0x00B50463 (beq) → is_br=1, is_ls=0.
- With count=3, assert flush together with fetch_valid and issue_ready → next cycle count=0, issue_valid=0; the flushed-cycle push is not stored. Assert reset with count=2 → same empty state.
